// File: rtl/gpp_imem.sv
// Instruction memory for the GPP fetch side: byte-serial loader fills the array
// in LOAD, then the GPP reads 32-bit words with one cycle of latency in RUN.
module gpp_imem #(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32,
   parameter int D_W    = 32
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [ADDR_W-1:0] Addr,
   input  logic              RW,
   input  logic              En,
   output logic [D_W-1:0]    Data,
   input  logic              Ld_Valid,
   input  logic [7:0]        Ld_Byte,
   input  logic              Ld_Last,
   output logic              Ld_Ready,
   output logic              Mem_Ready,
   output logic [ADDR_W:0]   Prog_Len,
   output logic [1:0]        Err
);

   typedef enum logic {LOAD, RUN} state_t;

   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH-1);

   state_t          state;
   logic [1:0]      byte_cnt;
   logic [ADDR_W:0] wr_ptr;
   logic [D_W-1:0]  acc;
   logic [D_W-1:0]  mem [DEPTH];
   logic [D_W-1:0]  byte_word;
   logic [D_W-1:0]  asm_word;
   logic            accept;
   logic            word_wr;
   logic            in_range;

   assign accept   = (state == LOAD) && Ld_Valid && Ld_Ready;
   assign word_wr  = accept && ((byte_cnt == 2'd3) || Ld_Last);
   assign in_range = {1'b0, Addr} < Prog_Len;

   // Big-endian placement; bytes not yet received stay zero, which also
   // provides the padding for a short final word.
   always_comb begin
      byte_word = '0;
      case (byte_cnt)
         2'd0:    byte_word = {Ld_Byte, 24'h0};
         2'd1:    byte_word = {8'h0, Ld_Byte, 16'h0};
         2'd2:    byte_word = {16'h0, Ld_Byte, 8'h0};
         default: byte_word = {24'h0, Ld_Byte};
      endcase
      asm_word = ((byte_cnt == 2'd0) ? '0 : acc) | byte_word;
   end

   always_ff @(posedge Clk) begin
      if (accept) acc <= asm_word;
      if (word_wr) mem[wr_ptr[ADDR_W-1:0]] <= asm_word;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state     <= LOAD;
         byte_cnt  <= 2'd0;
         wr_ptr    <= '0;
         Data      <= '0;
         Ld_Ready  <= 1'b1;
         Mem_Ready <= 1'b0;
         Prog_Len  <= '0;
         Err       <= 2'b00;
      end else begin
         case (state)
            LOAD: begin
               if (En) begin
                  Data   <= '0;
                  Err[1] <= 1'b1;
               end
               if (accept) begin
                  byte_cnt <= byte_cnt + 2'd1;
                  if (word_wr) begin
                     byte_cnt <= 2'd0;
                     wr_ptr   <= wr_ptr + 1'b1;
                     Prog_Len <= wr_ptr + 1'b1;
                     if (Ld_Last && (byte_cnt != 2'd3)) Err[0] <= 1'b1;
                     // The array being full ends the load just like Ld_Last.
                     if (Ld_Last || (wr_ptr == LAST_IDX)) begin
                        state     <= RUN;
                        Ld_Ready  <= 1'b0;
                        Mem_Ready <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               if (En) begin
                  if (RW) Err[1] <= 1'b1;
                  else    Data   <= in_range ? mem[Addr] : '0;
               end
            end
         endcase
      end
   end

endmodule
